// File: rtl/memoredf_pkg.sv
// Shared types and default sizes for the budget-regulated scheduler.
// Holds the FSM state encoding, the default queue count and the register word type.
// No logic; imported by the window and top-level modules.
package memoredf_pkg;

  localparam int NQ_DEF    = 4;
  localparam int REG_W_DEF = 32;
  localparam int QID_W     = $clog2(NQ_DEF);

  typedef logic [REG_W_DEF-1:0] reg_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/budget_window.sv
// Per-queue refill window: counts the period, tracks the packets left in the window.
// Latency: has_budget reflects registered state; throttled is registered from next state.
// No backpressure: pop is a 1-cycle pulse and is applied on the edge it is seen.
module budget_window
  import memoredf_pkg::*;
#(
  parameter int REGISTER_SIZE = REG_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REGISTER_SIZE-1:0] budget,
  input  logic [REGISTER_SIZE-1:0] period,
  input  logic                     pop,
  output logic                     has_budget,
  output logic                     throttled
);

  localparam logic [REGISTER_SIZE-1:0] ONE = {{(REGISTER_SIZE-1){1'b0}}, 1'b1};

  logic [REGISTER_SIZE-1:0] r_cnt;
  logic [REGISTER_SIZE-1:0] r_remaining;
  logic                     r_throttled;

  logic                     w_unregulated;
  logic                     w_replenish;
  logic                     w_wrap;
  logic [REGISTER_SIZE-1:0] w_base;
  logic [REGISTER_SIZE-1:0] w_remaining_nxt;
  logic [REGISTER_SIZE-1:0] w_cnt_nxt;

  // period 0 means unregulated: the counter is pinned at 0 and the queue is never limited.
  // The compare uses >= so that a period shrunk below the running count wraps at once
  // instead of running around the whole counter range.
  assign w_unregulated = (period == '0);
  assign w_replenish   = (r_cnt == '0);
  assign w_wrap        = w_unregulated || (r_cnt >= (period - ONE));
  assign w_cnt_nxt     = w_wrap ? '0 : (r_cnt + ONE);

  // A pop that coincides with a replenish is charged against the freshly loaded budget.
  assign w_base          = w_replenish ? budget : r_remaining;
  assign w_remaining_nxt = (pop && (w_base != '0)) ? (w_base - ONE) : w_base;

  assign has_budget = w_unregulated || (r_remaining != '0);
  assign throttled  = r_throttled;

  // Window counter, remaining budget and throttled flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_remaining <= '0;
      r_throttled <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_remaining <= w_remaining_nxt;
      r_throttled <= !w_unregulated && (w_remaining_nxt == '0);
    end
  end

endmodule

// File: rtl/budget_regulated_scheduler.sv
// Round-robin grant over non-empty queues with budget left; drives selector id and serializer enable.
// Latency: enable rises 1 cycle after eligibility; 3 cycles minimum per packet (IDLE, GRANT, SETTLE).
// Backpressure: a grant is held indefinitely until consumed; budget is only checked at grant time.
module budget_regulated_scheduler
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = NQ_DEF,
  parameter int REGISTER_SIZE    = REG_W_DEF
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   budgets,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   periods,
  input  logic                                             consumed,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]              id,
  output logic                                             enable,
  output logic [NUMBER_OF_QUEUES-1:0]                      hasBeenConsumed,
  output logic [NUMBER_OF_QUEUES-1:0]                      throttled
);

  localparam int ID_W = $clog2(NUMBER_OF_QUEUES);

  sched_state_t                r_state;
  sched_state_t                w_state_nxt;
  logic [ID_W-1:0]             r_id;
  logic [ID_W-1:0]             w_id_nxt;
  logic [ID_W-1:0]             r_last;
  logic [ID_W-1:0]             w_last_nxt;
  logic                        r_enable;
  logic                        w_enable_nxt;
  logic [NUMBER_OF_QUEUES-1:0] r_pop;
  logic [NUMBER_OF_QUEUES-1:0] w_pop_nxt;

  logic [NUMBER_OF_QUEUES-1:0] w_has_budget;
  logic [NUMBER_OF_QUEUES-1:0] w_elig;
  logic [ID_W-1:0]             w_cand;
  logic [ID_W-1:0]             w_pick;
  logic                        w_pick_vld;

  for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_win
    budget_window #(
      .REGISTER_SIZE(REGISTER_SIZE)
    ) u_win (
      .clock     (clock),
      .reset     (reset),
      .budget    (budgets[g]),
      .period    (periods[g]),
      .pop       (r_pop[g]),
      .has_budget(w_has_budget[g]),
      .throttled (throttled[g])
    );
  end

  assign w_elig = ~empty & w_has_budget;

  // Round-robin pick: first eligible queue strictly after the last grant, wrapping mod NQ.
  // The queue count is a power of two, so the ID_W-bit add wraps on its own.
  always_comb begin
    w_cand     = r_last;
    w_pick     = r_last;
    w_pick_vld = 1'b0;
    for (int k = 1; k <= NUMBER_OF_QUEUES; k++) begin
      w_cand = r_last + k[ID_W-1:0];
      if (!w_pick_vld && w_elig[w_cand]) begin
        w_pick     = w_cand;
        w_pick_vld = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the grant FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_id_nxt     = r_id;
    w_last_nxt   = r_last;
    w_enable_nxt = r_enable;
    w_pop_nxt    = r_pop;
    case (r_state)
      IDLE: begin
        w_enable_nxt = 1'b0;
        w_pop_nxt    = '0;
        if (w_pick_vld) begin
          w_id_nxt     = w_pick;
          w_last_nxt   = w_pick;
          w_enable_nxt = 1'b1;
          w_state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (consumed) begin
          w_enable_nxt    = 1'b0;
          w_pop_nxt       = '0;
          w_pop_nxt[r_id] = 1'b1;
          w_state_nxt     = SETTLE;
        end
      end
      SETTLE: begin
        // Idle cycle so empty flags and remaining budgets reflect the pop before the next pick.
        w_pop_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_enable_nxt = 1'b0;
        w_pop_nxt    = '0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  // FSM state and output registers; reset drops any open grant without a pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_id     <= '0;
      r_last   <= ID_W'(NUMBER_OF_QUEUES - 1);
      r_enable <= 1'b0;
      r_pop    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_id     <= w_id_nxt;
      r_last   <= w_last_nxt;
      r_enable <= w_enable_nxt;
      r_pop    <= w_pop_nxt;
    end
  end

  assign id              = r_id;
  assign enable          = r_enable;
  assign hasBeenConsumed = r_pop;

endmodule

// File: tb/tb_budget_regulated_scheduler.sv
// Directed bench for budget_regulated_scheduler with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge of the clock.
// Every comparison is an immediate assertion that counts and reports its own failure.
module tb_budget_regulated_scheduler;
  import memoredf_pkg::*;

  logic                         clock = 1'b0;
  logic                         reset;
  logic [NQ_DEF-1:0]            empty;
  reg_word_t [NQ_DEF-1:0]       budgets;
  reg_word_t [NQ_DEF-1:0]       periods;
  logic                         consumed;
  logic [QID_W-1:0]             id;
  logic                         enable;
  logic [NQ_DEF-1:0]            hbc;
  logic [NQ_DEF-1:0]            throttled;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  budget_regulated_scheduler #(
    .NUMBER_OF_QUEUES(NQ_DEF),
    .REGISTER_SIZE   (REG_W_DEF)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .empty          (empty),
    .budgets        (budgets),
    .periods        (periods),
    .consumed       (consumed),
    .id             (id),
    .enable         (enable),
    .hasBeenConsumed(hbc),
    .throttled      (throttled)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at the falling edge where a grant to queue e is expected; ends two edges later
  // with the pop pulse cleared. The next grant, if any, is visible one edge after that.
  task automatic serve(input int e);
    check("grant_en", 32'(enable), 32'd1);
    check("grant_id", 32'(id), 32'(e));
    consumed = 1'b1;
    tick(1);
    check("pop_pulse", 32'(hbc), 32'(1) << e);
    check("pop_en_low", 32'(enable), 32'd0);
    consumed = 1'b0;
    tick(1);
    check("pop_clear", 32'(hbc), 32'd0);
  endtask

  // Pulse reset for one cycle; returns on the falling edge where reset is released (N0).
  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    int bad;
    int seq1 [5] = '{0, 1, 2, 3, 0};
    int seq6 [4] = '{0, 1, 2, 0};

    consumed = 1'b0;
    empty    = '1;
    budgets  = '0;
    periods  = '0;
    reset    = 1'b0;
    #1 reset = 1'b1;

    // Test 1: every queue non-empty and unregulated -> 0,1,2,3,0 at a 3-cycle cadence.
    empty = '0;
    for (int i = 0; i < NQ_DEF; i++) budgets[i] = 32'd1000;
    tick(1);
    check("rst_id", 32'(id), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_hbc", 32'(hbc), 32'd0);
    check("rst_throttled", 32'(throttled), 32'd0);
    reset = 1'b0;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      serve(seq1[k]);
      tick(1);
    end
    check("t1_unthrottled", 32'(throttled), 32'd0);

    // Test 2: only Q1, budget 2 per 20-cycle window.
    empty   = 4'b1101;
    budgets = '0;
    periods = '0;
    budgets[1] = 32'd2;
    periods[1] = 32'd20;
    do_reset();
    tick(1);
    check("t2_no_grant_before_refill", 32'(enable), 32'd0);
    tick(1);
    serve(1);
    tick(1);
    serve(1);
    check("t2_throttled", 32'(throttled), 32'b0010);
    check("t2_no_third", 32'(enable), 32'd0);
    consumed = 1'b1;
    tick(2);
    check("t2_consumed_ignored_hbc", 32'(hbc), 32'd0);
    check("t2_consumed_ignored_en", 32'(enable), 32'd0);
    consumed = 1'b0;
    tick(11);
    check("t2_still_idle", 32'(enable), 32'd0);
    check("t2_still_throttled", 32'(throttled), 32'b0010);
    tick(1);
    check("t2_refilled", 32'(throttled), 32'd0);
    tick(1);
    serve(1);

    // Test 3: pop lands on Q2's replenish edge with budget 3 -> only 2 more grants.
    empty   = 4'b1011;
    budgets = '0;
    periods = '0;
    budgets[2] = 32'd3;
    periods[2] = 32'd8;
    do_reset();
    tick(2);
    check("t3_grant_en", 32'(enable), 32'd1);
    check("t3_grant_id", 32'(id), 32'd2);
    tick(5);
    check("t3_hold", 32'(enable), 32'd1);
    consumed = 1'b1;
    tick(1);
    check("t3_pop", 32'(hbc), 32'b0100);
    consumed = 1'b0;
    tick(1);
    check("t3_pop_clear", 32'(hbc), 32'd0);
    tick(1);
    serve(2);
    tick(1);
    serve(2);
    check("t3_throttled", 32'(throttled), 32'b0100);
    tick(1);
    check("t3_no_third", 32'(enable), 32'd0);
    tick(1);
    check("t3_refilled", 32'(throttled), 32'd0);
    check("t3_still_idle", 32'(enable), 32'd0);
    tick(1);
    check("t3_next_window_en", 32'(enable), 32'd1);
    check("t3_next_window_id", 32'(id), 32'd2);

    // Test 4: hold the grant for 50 cycles across several window wraps.
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      if (enable !== 1'b1 || id !== 2'd2 || hbc !== 4'b0000) bad++;
    end
    check("t4_hold_stable", 32'(bad), 32'd0);
    consumed = 1'b1;
    tick(1);
    check("t4_single_pulse", 32'(hbc), 32'b0100);
    check("t4_id_kept", 32'(id), 32'd2);
    consumed = 1'b0;
    tick(1);
    check("t4_pulse_clear", 32'(hbc), 32'd0);

    // Test 6: Q3 has zero budget in a 10-cycle window; others unregulated.
    empty   = '0;
    budgets = '0;
    periods = '0;
    for (int i = 0; i < 3; i++) budgets[i] = 32'd1000;
    periods[3] = 32'd10;
    do_reset();
    tick(1);
    check("t6_q3_throttled", 32'(throttled), 32'b1000);
    for (int k = 0; k < 4; k++) begin
      serve(seq6[k]);
      tick(1);
    end
    check("t6_grant_en", 32'(enable), 32'd1);
    check("t6_grant_id", 32'(id), 32'd1);
    check("t6_q3_still_throttled", 32'(throttled), 32'b1000);

    // Test 5: reset asserted while the grant to Q1 is open clears outputs asynchronously.
    #2 reset = 1'b1;
    #1;
    check("t5_async_enable", 32'(enable), 32'd0);
    check("t5_async_hbc", 32'(hbc), 32'd0);
    check("t5_async_id", 32'(id), 32'd0);
    check("t5_async_throttled", 32'(throttled), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(1);
    check("t5_first_grant_en", 32'(enable), 32'd1);
    check("t5_first_grant_id", 32'(id), 32'd0);
    check("t5_no_pop", 32'(hbc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
